// File: rtl/if_stage_pkg.sv
// Shared widths, bus layouts and exception codes for the instruction-fetch stage.
// Bus field order matches the pre-IF and decode stages.
package if_stage_pkg;

   localparam int PFS_TO_FS_BUS_WD = 65;
   localparam int FS_TO_DS_BUS_WD  = 70;

   localparam logic [4:0] EXCODE_ADEL = 5'h04;

   typedef struct packed {
      logic        inst_ok;
      logic [31:0] inst;
      logic [31:0] pc;
   } pfs_to_fs_t;

   typedef struct packed {
      logic        ex;
      logic [4:0]  excode;
      logic [31:0] inst;
      logic [31:0] pc;
   } fs_to_ds_t;

   function automatic logic addr_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// FS->DS handshake: fetch drives valid and bus, decode returns allowin.
interface if_stage_if;
   import if_stage_pkg::*;

   logic                       fs_to_ds_valid;
   logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
   logic                       ds_allowin;

   modport master (
      output fs_to_ds_valid,
      output fs_to_ds_bus,
      input  ds_allowin
   );

   modport slave (
      input  fs_to_ds_valid,
      input  fs_to_ds_bus,
      output ds_allowin
   );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: collects the SRAM word for the PC from pre-IF, buffers
// it across decode stalls, tags misaligned fetches and drops responses of flushed requests.
module if_stage
   import if_stage_pkg::*;
(
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        pfs_to_fs_valid,
   input  logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
   input  logic                        pfs_data_waiting,
   output logic                        fs_allowin,
   output logic                        fs_valid,
   output logic                        fs_inst_buff_full,
   input  logic                        inst_sram_data_ok,
   input  logic [31:0]                 inst_sram_data,
   input  logic                        ws_eret,
   input  logic                        ws_ex,
   if_stage_if.master                  ds
);

   pfs_to_fs_t  pfs_bus;
   fs_to_ds_t   out_bus;

   logic [31:0] fs_pc;
   logic [31:0] inst_buf;
   logic        inst_got;
   logic [1:0]  discard_cnt;
   logic [1:0]  discard_nxt;
   logic [1:0]  discard_base;

   logic        flush;
   logic        data_hit;
   logic        fs_ready_go;
   logic        load;
   logic        capture;
   logic        ex;
   logic [31:0] inst_out;

   assign pfs_bus = pfs_to_fs_bus;
   assign flush   = ws_eret | ws_ex;

   // A response only belongs to this slot when no stale responses are still owed.
   assign data_hit          = inst_sram_data_ok & (discard_cnt == 2'd0) & fs_valid & ~inst_got;
   assign fs_ready_go       = inst_got | data_hit;
   assign fs_allowin        = ~fs_valid | (fs_ready_go & ds.ds_allowin);
   assign fs_inst_buff_full = fs_valid & inst_got;

   assign load    = fs_allowin & pfs_to_fs_valid & ~flush;
   assign capture = data_hit & ~ds.ds_allowin;

   assign inst_out = inst_got ? inst_buf : inst_sram_data;
   assign ex       = addr_misaligned(fs_pc);

   always_comb begin
      out_bus        = '0;
      out_bus.ex     = ex;
      out_bus.excode = ex ? EXCODE_ADEL : 5'd0;
      out_bus.inst   = (ex | ~fs_valid) ? 32'd0 : inst_out;
      out_bus.pc     = fs_pc;
   end

   assign ds.fs_to_ds_valid = fs_valid & fs_ready_go & ~flush;
   assign ds.fs_to_ds_bus   = out_bus;

   // Count the responses still in flight for requests killed by this flush.
   always_comb begin
      discard_base = {1'b0, fs_valid & ~inst_got & ~inst_sram_data_ok}
                   + {1'b0, pfs_data_waiting};
      discard_nxt  = discard_cnt;
      if (flush) begin
         if (inst_sram_data_ok && (discard_cnt != 2'd0) && (discard_base != 2'd0))
            discard_nxt = discard_base - 2'd1;
         else
            discard_nxt = discard_base;
      end else if ((discard_cnt != 2'd0) && inst_sram_data_ok) begin
         discard_nxt = discard_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fs_valid    <= 1'b0;
         fs_pc       <= 32'd0;
         inst_got    <= 1'b0;
         inst_buf    <= 32'd0;
         discard_cnt <= 2'd0;
      end else begin
         discard_cnt <= discard_nxt;

         if (flush)
            fs_valid <= 1'b0;
         else if (fs_allowin)
            fs_valid <= pfs_to_fs_valid;

         if (flush) begin
            inst_got <= 1'b0;
            inst_buf <= 32'd0;
         end else if (load) begin
            fs_pc    <= pfs_bus.pc;
            inst_got <= pfs_bus.inst_ok;
            inst_buf <= pfs_bus.inst;
         end else if (capture) begin
            inst_buf <= inst_sram_data;
            inst_got <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table plus a hand-written
// asynchronous-reset-during-stall sequence.
module tb_if_stage;
   import if_stage_pkg::*;

   logic                        clk;
   logic                        resetn;
   logic                        pfs_to_fs_valid;
   logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus;
   logic                        pfs_data_waiting;
   logic                        fs_allowin;
   logic                        fs_valid;
   logic                        fs_inst_buff_full;
   logic                        inst_sram_data_ok;
   logic [31:0]                 inst_sram_data;
   logic                        ws_eret;
   logic                        ws_ex;

   if_stage_if ds_bus ();

   if_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .pfs_to_fs_valid   (pfs_to_fs_valid),
      .pfs_to_fs_bus     (pfs_to_fs_bus),
      .pfs_data_waiting  (pfs_data_waiting),
      .fs_allowin        (fs_allowin),
      .fs_valid          (fs_valid),
      .fs_inst_buff_full (fs_inst_buff_full),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_data    (inst_sram_data),
      .ws_eret           (ws_eret),
      .ws_ex             (ws_ex),
      .ds                (ds_bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        pv;
      logic [31:0] pc;
      logic        inst_ok;
      logic [31:0] pinst;
      logic        waiting;
      logic        dok;
      logic [31:0] data;
      logic        dsa;
      logic [1:0]  flush;
      logic        e_allowin;
      logic        e_valid;
      logic        e_full;
      logic        e_tdv;
      logic [69:0] e_bus;
   } vec_t;

   vec_t vecs [20];
   int   n_cmp;
   int   n_fail;

   function automatic logic [69:0] bus_of(input logic ex, input logic [4:0] code,
                                          input logic [31:0] inst, input logic [31:0] pc);
      return {ex, code, inst, pc};
   endfunction

   function automatic vec_t mk(input logic pv, input logic [31:0] pc, input logic inst_ok,
                               input logic [31:0] pinst, input logic waiting, input logic dok,
                               input logic [31:0] data, input logic dsa, input logic [1:0] flush,
                               input logic e_allowin, input logic e_valid, input logic e_full,
                               input logic e_tdv, input logic [69:0] e_bus);
      vec_t v;
      v.pv = pv;           v.pc = pc;       v.inst_ok = inst_ok; v.pinst = pinst;
      v.waiting = waiting; v.dok = dok;     v.data = data;       v.dsa = dsa;
      v.flush = flush;     v.e_allowin = e_allowin; v.e_valid = e_valid;
      v.e_full = e_full;   v.e_tdv = e_tdv; v.e_bus = e_bus;
      return v;
   endfunction

   task automatic compare_val(input string name, input logic [69:0] act, input logic [69:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      pfs_to_fs_valid   = v.pv;
      pfs_to_fs_bus     = {v.inst_ok, v.pinst, v.pc};
      pfs_data_waiting  = v.waiting;
      inst_sram_data_ok = v.dok;
      inst_sram_data    = v.data;
      ds_bus.ds_allowin = v.dsa;
      ws_eret           = v.flush[1];
      ws_ex             = v.flush[0];
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      compare_val($sformatf("v%0d fs_allowin", idx), 70'(fs_allowin), 70'(v.e_allowin));
      compare_val($sformatf("v%0d fs_valid", idx), 70'(fs_valid), 70'(v.e_valid));
      compare_val($sformatf("v%0d fs_inst_buff_full", idx), 70'(fs_inst_buff_full), 70'(v.e_full));
      compare_val($sformatf("v%0d fs_to_ds_valid", idx), 70'(ds_bus.fs_to_ds_valid), 70'(v.e_tdv));
      if (v.e_tdv)
         compare_val($sformatf("v%0d fs_to_ds_bus", idx), ds_bus.fs_to_ds_bus, v.e_bus);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;

      // Sequential fetch, then a three-cycle decode stall.
      vecs[0]  = mk(1, 32'hBFC00000, 0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0, '0);
      vecs[1]  = mk(0, 0, 0, 0, 0, 1, 32'h24080001, 1, 2'b00, 1, 1, 0, 1,
                    bus_of(0, 5'd0, 32'h24080001, 32'hBFC00000));
      vecs[2]  = mk(1, 32'hBFC00004, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, '0);
      vecs[3]  = mk(0, 0, 0, 0, 0, 1, 32'h11223344, 0, 2'b00, 0, 1, 0, 1,
                    bus_of(0, 5'd0, 32'h11223344, 32'hBFC00004));
      vecs[4]  = mk(0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 2'b00, 0, 1, 1, 1,
                    bus_of(0, 5'd0, 32'h11223344, 32'hBFC00004));
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 2'b00, 0, 1, 1, 1,
                    bus_of(0, 5'd0, 32'h11223344, 32'hBFC00004));
      vecs[6]  = mk(0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 2'b00, 1, 1, 1, 1,
                    bus_of(0, 5'd0, 32'h11223344, 32'hBFC00004));
      // Early data carried by pre-IF, then a misaligned fetch.
      vecs[7]  = mk(1, 32'hBFC00008, 1, 32'hDEADBEEF, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0, '0);
      vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 1, 1, 1,
                    bus_of(0, 5'd0, 32'hDEADBEEF, 32'hBFC00008));
      vecs[9]  = mk(1, 32'hBFC00002, 0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0, '0);
      vecs[10] = mk(0, 0, 0, 0, 0, 1, 32'h12345678, 1, 2'b00, 1, 1, 0, 1,
                    bus_of(1, 5'h04, 32'd0, 32'hBFC00002));
      // Flush with two responses outstanding: next two data_ok are dropped.
      vecs[11] = mk(1, 32'hBFC00010, 0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0, '0);
      vecs[12] = mk(0, 0, 0, 0, 1, 0, 0, 1, 2'b01, 0, 1, 0, 0, '0);
      vecs[13] = mk(1, 32'hBFC00380, 0, 0, 1, 1, 32'hAAAA0001, 1, 2'b00, 1, 0, 0, 0, '0);
      vecs[14] = mk(0, 0, 0, 0, 0, 1, 32'hAAAA0002, 1, 2'b00, 0, 1, 0, 0, '0);
      vecs[15] = mk(0, 0, 0, 0, 0, 1, 32'h3C1A0001, 1, 2'b00, 1, 1, 0, 1,
                    bus_of(0, 5'd0, 32'h3C1A0001, 32'hBFC00380));
      // Flush (eret) landing on the same cycle as the slot's own data_ok.
      vecs[16] = mk(1, 32'hBFC00020, 0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0, '0);
      vecs[17] = mk(0, 0, 0, 0, 0, 1, 32'h55555555, 1, 2'b10, 1, 1, 0, 0, '0);
      vecs[18] = mk(1, 32'hBFC00380, 0, 0, 0, 0, 0, 1, 2'b00, 1, 0, 0, 0, '0);
      vecs[19] = mk(0, 0, 0, 0, 0, 1, 32'h66666666, 1, 2'b00, 1, 1, 0, 1,
                    bus_of(0, 5'd0, 32'h66666666, 32'hBFC00380));

      resetn = 1'b1;
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, '0));
      #2 resetn = 1'b0;
      @(negedge clk);
      compare_val("reset fs_allowin", 70'(fs_allowin), 70'd1);
      compare_val("reset fs_valid", 70'(fs_valid), 70'd0);
      compare_val("reset fs_to_ds_valid", 70'(ds_bus.fs_to_ds_valid), 70'd0);
      compare_val("reset fs_inst_buff_full", 70'(fs_inst_buff_full), 70'd0);
      compare_val("reset fs_to_ds_bus", ds_bus.fs_to_ds_bus, 70'd0);
      @(posedge clk);
      #1 resetn = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput(vecs[i], i);
      end

      // Asynchronous reset while the instruction buffer is full.
      @(posedge clk);
      #1 applyStimulus(mk(1, 32'hBFC00040, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, '0));
      @(posedge clk);
      #1 applyStimulus(mk(0, 0, 0, 0, 0, 1, 32'h77777777, 0, 2'b00, 0, 0, 0, 0, '0));
      @(posedge clk);
      #1 applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, '0));
      @(negedge clk);
      compare_val("stall fs_inst_buff_full", 70'(fs_inst_buff_full), 70'd1);
      compare_val("stall fs_allowin", 70'(fs_allowin), 70'd0);
      compare_val("stall fs_to_ds_bus", ds_bus.fs_to_ds_bus,
                  bus_of(0, 5'd0, 32'h77777777, 32'hBFC00040));
      #1;
      resetn = 1'b0;
      applyStimulus(mk(0, 0, 0, 0, 0, 1, 32'h12345678, 1, 2'b00, 0, 0, 0, 0, '0));
      #1;
      compare_val("rst fs_to_ds_valid", 70'(ds_bus.fs_to_ds_valid), 70'd0);
      compare_val("rst fs_allowin", 70'(fs_allowin), 70'd1);
      compare_val("rst fs_inst_buff_full", 70'(fs_inst_buff_full), 70'd0);
      compare_val("rst fs_valid", 70'(fs_valid), 70'd0);
      compare_val("rst fs_to_ds_bus", ds_bus.fs_to_ds_bus, 70'd0);
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      compare_val("post-rst fs_to_ds_valid", 70'(ds_bus.fs_to_ds_valid), 70'd0);
      compare_val("post-rst fs_valid", 70'(fs_valid), 70'd0);
      compare_val("post-rst fs_inst_buff_full", 70'(fs_inst_buff_full), 70'd0);
      compare_val("post-rst fs_to_ds_bus", ds_bus.fs_to_ds_bus, 70'd0);
      @(posedge clk);
      #1 inst_sram_data_ok = 1'b0;
      @(negedge clk);
      compare_val("post-rst idle fs_valid", 70'(fs_valid), 70'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly downstream of `pre_if_stage`. It accepts the PC, and possibly an early-returned instruction word, from the pre-IF stage. It collects the instruction from the inst SRAM data channel if the word has not yet arrived, and buffers it while decode is stalled. It tags fetch address errors, discards SRAM responses that belong to flushed requests, and drives the FS→DS bus.

## Interface
Parameters: none. Widths come from `mycpu.h`.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `pfs_to_fs_valid` in 1: pre-IF has a fetched PC ready.
- `pfs_to_fs_bus` in `PFS_TO_FS_BUS_WD` (65): {inst_ok[64], inst[63:32], pc[31:0]}.
- `pfs_data_waiting` in 1: pre-IF has an accepted request whose data has not yet returned.
- `fs_allowin` out 1: this stage can accept a new PC this cycle.
- `fs_valid` out 1: this stage holds a live instruction slot.
- `fs_inst_buff_full` out 1: this stage already owns its instruction word, so any next `data_ok` belongs to pre-IF.
- `inst_sram_data_ok` in 1: read data valid this cycle.
- `inst_sram_data` in 32: read data.
- `ds_allowin` in 1: decode stage can accept.
- `fs_to_ds_valid` out 1: FS→DS handshake valid.
- `fs_to_ds_bus` out `FS_TO_DS_BUS_WD` (70): {ex[69], excode[68:64], inst[63:32], pc[31:0]}.
- `ws_eret` in 1: pipeline flush request from writeback.
- `ws_ex` in 1: pipeline flush request from writeback.

## Operation
- `flush = ws_eret | ws_ex`.
- Registers and their reset values (asynchronous, on `resetn`=0):
  - `fs_valid` = 0
  - `fs_pc` = 0
  - `inst_got` = 0
  - `inst_buf` = 0
  - `discard_cnt` = 0
- Outputs during reset: `fs_allowin`=1, `fs_to_ds_valid`=0, `fs_to_ds_bus`=0, `fs_inst_buff_full`=0.
- `data_hit = inst_sram_data_ok & (discard_cnt==0) & fs_valid & ~inst_got`.
- `fs_ready_go = inst_got | data_hit`.
- `fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin)`.
- `fs_inst_buff_full = fs_valid & inst_got`.
- `fs_valid` update:
  - `flush` → 0.
  - Otherwise, if `fs_allowin` → `pfs_to_fs_valid`.
- Load from pre-IF (`fs_allowin & pfs_to_fs_valid & ~flush`):
  - `fs_pc` ← bus pc.
  - `inst_got` ← bus inst_ok.
  - `inst_buf` ← bus inst.
- Capture while stalled (`data_hit & ~ds_allowin`):
  - `inst_buf` ← `inst_sram_data`.
  - `inst_got` ← 1.
- Instruction bypass: `inst_out = inst_got ? inst_buf : inst_sram_data`.
- Exception tagging:
  - `ex = (fs_pc[1:0] != 0)`.
  - `excode = ex ? EXCODE_ADEL : 0`.
  - `inst` field forced to 0 when `ex`; `pc` field carries the bad vaddr.
- `fs_to_ds_valid = fs_valid & fs_ready_go & ~flush`.
- Discard counter (2-bit), response-drop state:
  - On `flush`: `discard_cnt` ← (`fs_valid & ~inst_got & ~inst_sram_data_ok`) + `pfs_data_waiting`, minus 1 if `inst_sram_data_ok` arrives this cycle and `discard_cnt` was nonzero.
  - When not flushing and `discard_cnt != 0`: each `inst_sram_data_ok` decrements it. Those responses are ignored: no capture, no handshake.
  - Saturates: never wraps below 0 or above 3.
- On `flush`: `inst_got` ← 0, `inst_buf` ← 0.

## Timing
- Zero-cycle bypass: data returning in the cycle FS is valid and DS allows in produces `fs_to_ds_valid` in that same cycle.
- If DS stalls, the word is registered. DS sees it from `inst_buf` in every later cycle until accepted.
- An instruction returned early via pre-IF (inst_ok=1) makes `fs_ready_go`=1 in the first cycle after load.
- Flush in cycle N:
  - `fs_to_ds_valid`=0 in cycle N.
  - `fs_valid`=0 in cycle N+1.
  - Pre-IF redirect is accepted normally from N+1 (`fs_allowin`=1).
- Flush and `data_ok` in the same cycle: that response counts as one of the discarded responses when one was outstanding; the word is never delivered.
- Reset deassertion mid-transaction: all state is cleared; SRAM responses arriving after reset are ignored because `fs_valid`=0.

## Structure
- `mycpu.h` additions:
  - `FS_TO_DS_BUS_WD` = 70.
  - `EXCODE_ADEL` = 5'h04.
  - Reuse the existing `PFS_TO_FS_BUS_WD`.
- Single module, no sub-modules. The discard counter stays inline (small).

## Test plan
- Sequential fetch:
  - Stimulus: PC 0xBFC00000, data_ok one cycle after load with 0x24080001, `ds_allowin`=1.
  - Response: `fs_to_ds_valid` in the data_ok cycle, bus inst=0x24080001, pc=0xBFC00000, ex=0.
- DS stall:
  - Stimulus: `ds_allowin`=0 for 3 cycles while data 0x11223344 returns.
  - Response: `fs_inst_buff_full`=1 and `fs_allowin`=0 during the stall; inst held at 0x11223344; delivered on the first `ds_allowin`=1 cycle.
- Early data via pre-IF:
  - Stimulus: bus inst_ok=1, inst=0xDEADBEEF.
  - Response: `fs_to_ds_valid`=1 in the cycle after load, with no data_ok required.
- Address error:
  - Stimulus: pc=0xBFC00002, data_ok with data 0x12345678.
  - Response: ex=1, excode=0x04, inst=0, pc=0xBFC00002.
- Flush with two outstanding requests:
  - Stimulus: `fs_valid` with inst not yet returned, `pfs_data_waiting`=1, `ws_ex` pulse.
  - Response: `discard_cnt`=2; the next two data_ok pulses are dropped; the third data_ok delivers the redirected instruction.
- Async reset mid-stall:
  - Stimulus: assert `resetn`=0 while the buffer is full.
  - Response: immediately `fs_to_ds_valid`=0 and `fs_allowin`=1; all registers are 0 after release.
